// File: rtl/memory_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_controller_pkg
// Purpose  : Shared definitions for the memory controller: funct3 codes,
//            controller state encoding, request kinds, IO region select and
//            a helper that maps funct3 to an access size in bytes.
// Revision : 1.0 - initial release
// ============================================================================
package memory_controller_pkg;

    localparam logic       TRUE            = 1'b1;
    localparam logic       FALSE           = 1'b0;

    // Default value of addr[17:16] that selects the IO region.
    localparam logic [1:0] IO_BASE_DEFAULT = 2'b11;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STORE = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FETCH = 3'd3,
        ST_DONE  = 3'd4
    } mc_state_e;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_STORE = 2'd1,
        REQ_LOAD  = 2'd2,
        REQ_FETCH = 2'd3
    } req_kind_e;

    // Access size in bytes; the unused encoding 11 is treated as a word.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_controller_if
// Purpose  : Request/response handshakes of the LSB store and load ports and
//            the instruction fetcher, plus the byte-wide RAM/IO bus.
// Modports : slave  - the memory controller
//            master - the core requesters and the RAM (drives mem_din)
// Revision : 1.0 - initial release
// ============================================================================
interface memory_controller_if;
    // LSB store port
    logic        lsb_store;
    logic [31:0] store_address;
    logic [31:0] data_store;
    logic [5:0]  op_type_store;
    logic        finish_store;
    // LSB load port
    logic        lsb_load;
    logic [31:0] load_address;
    logic [5:0]  op_type_load;
    logic        finish_load;
    logic [31:0] data_load;
    // Instruction fetch port
    logic        ifetch_req;
    logic [31:0] ifetch_addr;
    logic        ifetch_done;
    logic [31:0] ifetch_data;
    // Byte-wide RAM/IO bus
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport slave (
        input  lsb_store, store_address, data_store, op_type_store,
        input  lsb_load, load_address, op_type_load,
        input  ifetch_req, ifetch_addr,
        input  mem_din,
        output finish_store, finish_load, data_load,
        output ifetch_done, ifetch_data,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output lsb_store, store_address, data_store, op_type_store,
        output lsb_load, load_address, op_type_load,
        output ifetch_req, ifetch_addr,
        output mem_din,
        input  finish_store, finish_load, data_load,
        input  ifetch_done, ifetch_data,
        input  mem_dout, mem_a, mem_wr
    );
endinterface
`default_nettype wire

// File: rtl/memory_controller_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : memory_controller_load_extend
// Purpose  : Turns the assembled little-endian read bytes into the 32-bit
//            load result according to funct3 (sign/zero extension).
// Ports    : bytes_i  [31:0] assembled bytes, byte 0 in [7:0]
//            funct3_i [2:0]  load funct3
//            data_o   [31:0] extended result
// Revision : 1.0 - initial release
// ============================================================================
module memory_controller_load_extend
    import memory_controller_pkg::*;
(
    input  logic [31:0] bytes_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    always_comb begin
        case (funct3_i)
            F3_LB:   data_o = {{24{bytes_i[7]}},  bytes_i[7:0]};
            F3_LH:   data_o = {{16{bytes_i[15]}}, bytes_i[15:0]};
            F3_LBU:  data_o = {24'd0, bytes_i[7:0]};
            F3_LHU:  data_o = {16'd0, bytes_i[15:0]};
            default: data_o = bytes_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : memory_controller
// Purpose  : Arbitrates store > load > fetch requests onto a byte-wide RAM/IO
//            bus, serialising each request into byte accesses, assembling and
//            extending read data, and returning a one-cycle done pulse.
// Ports    : clk_in         system clock
//            rst_in         synchronous reset, active low
//            rdy_in         global pause (all state frozen when low)
//            roll_back      misprediction flush (aborts loads/fetches)
//            io_buffer_full stalls writes into the IO region
//            bus            memory_controller_if.slave handshakes + RAM bus
// Revision : 1.0 - initial release
// ============================================================================
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter logic [1:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               roll_back,
    input  logic               io_buffer_full,
    memory_controller_if.slave bus
);

    mc_state_e   state_q, state_d;
    req_kind_e   kind_q,  kind_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] bytes_q, bytes_d;
    logic [2:0]  f3_q,    f3_d;
    logic [2:0]  cnt_q,   cnt_d;

    logic [2:0]  size;
    logic        io_stall;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        fin_store;
    logic        fin_load;
    logic        fetch_done;
    logic [31:0] ext_data;
    logic        unused_op_bits;

    assign size     = size_bytes(f3_q);
    assign io_stall = (addr_q[17:16] == IO_BASE) && io_buffer_full;

    memory_controller_load_extend u_extend (
        .bytes_i  (bytes_q),
        .funct3_i (f3_q),
        .data_o   (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bytes_d    = bytes_q;
        f3_d       = f3_q;
        cnt_d      = cnt_q;
        mem_a      = 32'd0;
        mem_dout   = 8'd0;
        mem_wr     = 1'b0;
        fin_store  = 1'b0;
        fin_load   = 1'b0;
        fetch_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 3'd0;
                if (bus.lsb_store) begin
                    state_d = ST_STORE;
                    kind_d  = REQ_STORE;
                    addr_d  = bus.store_address;
                    wdata_d = bus.data_store;
                    f3_d    = bus.op_type_store[2:0];
                end else if (bus.lsb_load) begin
                    state_d = ST_LOAD;
                    kind_d  = REQ_LOAD;
                    addr_d  = bus.load_address;
                    f3_d    = bus.op_type_load[2:0];
                end else if (bus.ifetch_req) begin
                    state_d = ST_FETCH;
                    kind_d  = REQ_FETCH;
                    addr_d  = bus.ifetch_addr;
                    f3_d    = F3_LW;
                end
            end

            ST_STORE: begin
                // A full IO buffer holds the current byte on the bus without
                // writing it; the store is committed so roll_back is ignored.
                mem_a    = addr_q + {29'd0, cnt_q};
                mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                mem_wr   = !io_stall;
                if (!io_stall) begin
                    if (cnt_q == size - 3'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            ST_LOAD, ST_FETCH: begin
                // cnt_q walks 0..size: addresses go out for 0..size-1 and the
                // byte requested on the previous cycle arrives for 1..size.
                if (cnt_q < size) begin
                    mem_a = addr_q + {29'd0, cnt_q};
                end
                if (cnt_q != 3'd0) begin
                    // cnt 4 wraps to 0 in two bits, so 0-1 selects byte 3.
                    bytes_d[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = bus.mem_din;
                end
                if (cnt_q == size) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
                if (roll_back) begin
                    state_d = ST_IDLE;
                    kind_d  = REQ_NONE;
                end
            end

            ST_DONE: begin
                fin_store  = (kind_q == REQ_STORE);
                fin_load   = (kind_q == REQ_LOAD)  && !roll_back;
                fetch_done = (kind_q == REQ_FETCH) && !roll_back;
                state_d    = ST_IDLE;
                kind_d     = REQ_NONE;
            end

            default: begin
                state_d = ST_IDLE;
                kind_d  = REQ_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            kind_q  <= REQ_NONE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            bytes_q <= 32'd0;
            f3_q    <= 3'd0;
            cnt_q   <= 3'd0;
        end else if (rdy_in) begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bytes_q <= bytes_d;
            f3_q    <= f3_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mem_a        = mem_a;
    assign bus.mem_dout     = mem_dout;
    assign bus.mem_wr       = mem_wr;
    assign bus.finish_store = fin_store;
    assign bus.finish_load  = fin_load;
    assign bus.ifetch_done  = fetch_done;
    assign bus.data_load    = ext_data;
    assign bus.ifetch_data  = bytes_q;

    // Only funct3 of the 6-bit op types matters here.
    assign unused_op_bits = ^{bus.op_type_store[5:3], bus.op_type_load[5:3]};

endmodule
`default_nettype wire

// File: tb/tb_memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_controller
// Purpose  : Self-checking bench for memory_controller: vector table, directed
//            multi-cycle sequences and randomized traffic against a byte-array
//            reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_controller;
    import memory_controller_pkg::*;

    localparam int K_ST = 0;
    localparam int K_LD = 1;
    localparam int K_IF = 2;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    logic roll_back = 1'b0;
    logic io_buffer_full = 1'b0;

    memory_controller_if bus ();

    memory_controller #(.IO_BASE(2'b11)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .roll_back      (roll_back),
        .io_buffer_full (io_buffer_full),
        .bus            (bus)
    );

    always #5 clk_in = ~clk_in;

    bit [7:0] ram  [bit [31:0]];
    bit [7:0] gold [bit [31:0]];
    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;

    function automatic bit [7:0] ram_rd(input bit [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic bit [7:0] gold_rd(input bit [31:0] a);
        return gold.exists(a) ? gold[a] : 8'h00;
    endfunction

    // RAM: read data appears the cycle after its address; paused by rdy_in.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            bus.mem_din <= ram_rd(bus.mem_a);
            if (bus.mem_wr) begin
                ram[bus.mem_a] = bus.mem_dout;
                wr_count++;
            end
        end
    end

    function automatic int nbytes(input logic [2:0] f3, input bit fetch);
        if (fetch) return 4;
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input bit fetch);
        longint v;
        int n;
        n = nbytes(f3, fetch);
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(gold_rd(32'(a + 32'(k)))) << (8 * k);
        if (!fetch && f3 == 3'b000 && v >= 128)   v -= 256;
        if (!fetch && f3 == 3'b001 && v >= 32768) v -= 65536;
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < nbytes(f3, 1'b0); k++) gold[32'(a + 32'(k))] = 8'((d >> (8 * k)) & 32'hFF);
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        gold[a] = b;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, expv);
        end
    endtask

    function automatic logic [2:0] dones();
        return {bus.finish_store, bus.finish_load, bus.ifetch_done};
    endfunction

    task automatic clear_req();
        bus.lsb_store = 1'b0;
        bus.lsb_load  = 1'b0;
        bus.ifetch_req = 1'b0;
    endtask

    task automatic set_req(input int kind, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bus.lsb_store     = (kind == K_ST);
        bus.store_address = a;
        bus.data_store    = d;
        bus.op_type_store = {3'b000, f3};
        bus.lsb_load      = (kind == K_LD);
        bus.load_address  = a;
        bus.op_type_load  = {3'b000, f3};
        bus.ifetch_req    = (kind == K_IF);
        bus.ifetch_addr   = a;
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic rand_env();
        rdy_in = ($urandom_range(0, 3) != 0);
        io_buffer_full = ($urandom_range(0, 2) == 0);
    endtask

    // Issues one request (cycle 0), returns the cycle of its done pulse and
    // the returned data, then checks the pulse lasted a single cycle.
    task automatic run_req(input int kind, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input bit rnd,
                           output int lat, output logic [31:0] got);
        int cyc;
        bit seen;
        logic [2:0] onehot;
        onehot = (kind == K_ST) ? 3'b100 : (kind == K_LD) ? 3'b010 : 3'b001;
        lat = -1; got = '0; seen = 1'b0; cyc = 0;
        next_cycle();
        set_req(kind, f3, a, d);
        if (rnd) rand_env(); else begin rdy_in = 1'b1; io_buffer_full = 1'b0; end
        while (!seen && cyc < 400) begin
            @(negedge clk_in);
            if (dones() != 3'b000) begin
                seen = 1'b1;
                lat = cyc;
                check("done_select", 32'(dones()), 32'(onehot));
                got = (kind == K_IF) ? bus.ifetch_data : bus.data_load;
                clear_req();
                rdy_in = 1'b1;
                io_buffer_full = 1'b0;
            end else begin
                next_cycle();
                cyc++;
                if (rnd) rand_env();
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        clear_req();
        rdy_in = 1'b1;
        next_cycle();
        @(negedge clk_in);
        check("single_pulse", 32'(dones()), 32'd0);
    endtask

    typedef struct {
        int          kind;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [13];
    logic [2:0] load_f3s [5];

    initial begin
        int lat;
        int wr0;
        int n;
        int c_st, c_ld, c_if, p_st, p_ld, p_if, multi;
        logic [31:0] got, d_ld, d_if, exp_ld, exp_if;

        clear_req();
        set_req(K_LD, 3'b000, 32'd0, 32'd0);
        clear_req();
        poke(32'h1000, 8'h78); poke(32'h1001, 8'h56);
        poke(32'h1002, 8'h34); poke(32'h1003, 8'h12);
        poke(32'h2000, 8'h80); poke(32'h2001, 8'hFF);

        vecs[0]  = '{K_LD, F3_LW,  32'h0000_1000, 32'h0,          6, 32'h1234_5678};
        vecs[1]  = '{K_LD, F3_LB,  32'h0000_2000, 32'h0,          3, 32'hFFFF_FF80};
        vecs[2]  = '{K_LD, F3_LBU, 32'h0000_2000, 32'h0,          3, 32'h0000_0080};
        vecs[3]  = '{K_LD, F3_LH,  32'h0000_2000, 32'h0,          4, 32'hFFFF_FF80};
        vecs[4]  = '{K_LD, F3_LHU, 32'h0000_2000, 32'h0,          4, 32'h0000_FF80};
        vecs[5]  = '{K_IF, F3_LW,  32'h0000_1000, 32'h0,          6, 32'h1234_5678};
        vecs[6]  = '{K_ST, F3_SH,  32'h0000_2002, 32'hABCD_1234,  3, 32'h0};
        vecs[7]  = '{K_LD, F3_LW,  32'h0000_2000, 32'h0,          6, 32'h1234_FF80};
        vecs[8]  = '{K_ST, F3_SW,  32'hFFFF_FFFE, 32'hDEAD_BEEF,  5, 32'h0};
        vecs[9]  = '{K_LD, F3_LW,  32'hFFFF_FFFE, 32'h0,          6, 32'hDEAD_BEEF};
        vecs[10] = '{K_LD, F3_LB,  32'h0000_1001, 32'h0,          3, 32'h0000_0056};
        vecs[11] = '{K_ST, F3_SB,  32'h0000_3000, 32'h0000_005A,  2, 32'h0};
        vecs[12] = '{K_LD, F3_LBU, 32'h0000_3000, 32'h0,          3, 32'h0000_005A};
        load_f3s = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};

        // Reset state
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("reset_bus", {bus.mem_wr, bus.mem_dout, bus.mem_a[22:0]}, 32'd0);
        check("reset_mem_a", bus.mem_a, 32'd0);
        check("reset_done", 32'(dones()), 32'd0);
        check("reset_data_load", bus.data_load, 32'd0);
        check("reset_ifetch_data", bus.ifetch_data, 32'd0);
        next_cycle();
        rst_in = 1'b1;

        // Vector table
        for (int i = 0; i < 13; i++) begin
            wr0 = wr_count;
            run_req(vecs[i].kind, vecs[i].f3, vecs[i].addr, vecs[i].data, 1'b0, lat, got);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].kind == K_ST) begin
                ref_store(vecs[i].f3, vecs[i].addr, vecs[i].data);
                n = nbytes(vecs[i].f3, 1'b0);
                check($sformatf("vec%0d_writes", i), 32'(wr_count - wr0), 32'(n));
                for (int k = -1; k <= n; k++)
                    check($sformatf("vec%0d_byte%0d", i, k),
                          32'(ram_rd(32'(vecs[i].addr + 32'(k)))),
                          32'(gold_rd(32'(vecs[i].addr + 32'(k)))));
            end else begin
                check($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
                check($sformatf("vec%0d_no_writes", i), 32'(wr_count - wr0), 32'd0);
            end
        end

        // Store, load and fetch requested together
        exp_ld = ref_load(F3_LW, 32'h1000, 1'b0);
        exp_if = ref_load(F3_LW, 32'h2000, 1'b1);
        next_cycle();
        bus.lsb_store = 1'b1; bus.store_address = 32'h4000; bus.data_store = 32'h1122_3344;
        bus.op_type_store = {3'b000, F3_SW};
        bus.lsb_load = 1'b1; bus.load_address = 32'h1000; bus.op_type_load = {3'b000, F3_LW};
        bus.ifetch_req = 1'b1; bus.ifetch_addr = 32'h2000;
        c_st = -1; c_ld = -1; c_if = -1; p_st = 0; p_ld = 0; p_if = 0; multi = 0;
        d_ld = '0; d_if = '0;
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk_in);
            if ($countones(dones()) > 1) multi++;
            if (bus.finish_store) begin p_st++; c_st = c; bus.lsb_store = 1'b0; end
            if (bus.finish_load)  begin p_ld++; c_ld = c; d_ld = bus.data_load; bus.lsb_load = 1'b0; end
            if (bus.ifetch_done)  begin p_if++; c_if = c; d_if = bus.ifetch_data; bus.ifetch_req = 1'b0; end
        end
        ref_store(F3_SW, 32'h4000, 32'h1122_3344);
        check("prio_store_cycle", 32'(c_st), 32'd5);
        check("prio_load_cycle", 32'(c_ld), 32'd12);
        check("prio_fetch_cycle", 32'(c_if), 32'd19);
        check("prio_pulse_counts", {8'(p_st), 8'(p_ld), 8'(p_if)}, 32'h0001_0101);
        check("prio_overlap", 32'(multi), 32'd0);
        check("prio_load_data", d_ld, exp_ld);
        check("prio_fetch_data", d_if, exp_if);

        // roll_back in cycle 2 of an LW, then an LB issued in cycle 3
        exp_ld = ref_load(F3_LB, 32'h2000, 1'b0);
        next_cycle();
        set_req(K_LD, F3_LW, 32'h1000, 32'h0);
        c_ld = -1; p_ld = 0; d_ld = '0;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            if (c == 2) begin roll_back = 1'b1; clear_req(); end
            if (c == 3) begin roll_back = 1'b0; set_req(K_LD, F3_LB, 32'h2000, 32'h0); end
            @(negedge clk_in);
            if (c == 3) begin
                check("rollback_idle_mem_a", bus.mem_a, 32'd0);
                check("rollback_idle_mem_wr", 32'(bus.mem_wr), 32'd0);
            end
            if (bus.finish_load) begin
                p_ld++;
                if (c_ld < 0) c_ld = c;
                d_ld = bus.data_load;
                clear_req();
            end
        end
        check("rollback_load_pulses", 32'(p_ld), 32'd1);
        check("rollback_next_load_cycle", 32'(c_ld), 32'd6);
        check("rollback_next_load_data", d_ld, exp_ld);

        // roll_back held during an SW: store still completes
        wr0 = wr_count;
        next_cycle();
        set_req(K_ST, F3_SW, 32'h5000, 32'hCAFE_F00D);
        c_st = -1;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            roll_back = (c <= 5);
            @(negedge clk_in);
            if (bus.finish_store && c_st < 0) begin c_st = c; clear_req(); end
        end
        roll_back = 1'b0;
        ref_store(F3_SW, 32'h5000, 32'hCAFE_F00D);
        check("rollback_store_cycle", 32'(c_st), 32'd5);
        check("rollback_store_writes", 32'(wr_count - wr0), 32'd4);
        check("rollback_store_word",
              {ram_rd(32'h5003), ram_rd(32'h5002), ram_rd(32'h5001), ram_rd(32'h5000)},
              32'hCAFE_F00D);

        // SB into the IO region with the buffer full for three cycles
        wr0 = wr_count;
        next_cycle();
        set_req(K_ST, F3_SB, 32'h0003_0000, 32'h0000_00A5);
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            io_buffer_full = (c <= 3);
            @(negedge clk_in);
            if (c <= 3) check($sformatf("io_stall_c%0d", c), {bus.mem_wr, bus.mem_a[30:0]}, 32'h0003_0000);
            if (c == 4) check("io_write", {23'd0, bus.mem_wr, bus.mem_dout}, 32'h0000_01A5);
            if (c == 4) check("io_write_addr", bus.mem_a, 32'h0003_0000);
            if (c == 5) begin check("io_finish", 32'(dones()), 32'b100); clear_req(); end
        end
        check("io_writes", 32'(wr_count - wr0), 32'd1);
        next_cycle();

        // Randomized traffic against the reference memory
        for (int t = 0; t < 150; t++) begin
            int kind;
            logic [2:0] f3;
            logic [31:0] a, d;
            kind = $urandom_range(0, 2);
            f3 = (kind == K_ST) ? 3'($urandom_range(0, 2)) : load_f3s[$urandom_range(0, 4)];
            a = (($urandom_range(0, 1) == 1) ? 32'h0003_0100 : 32'h0000_0100) + 32'($urandom_range(0, 23));
            d = $urandom;
            wr0 = wr_count;
            run_req(kind, f3, a, d, 1'b1, lat, got);
            if (kind == K_ST) begin
                ref_store(f3, a, d);
                n = nbytes(f3, 1'b0);
                check($sformatf("rnd%0d_writes", t), 32'(wr_count - wr0), 32'(n));
                for (int k = 0; k < n; k++)
                    check($sformatf("rnd%0d_byte%0d", t, k),
                          32'(ram_rd(32'(a + 32'(k)))), 32'(gold_rd(32'(a + 32'(k)))));
            end else begin
                check($sformatf("rnd%0d_data", t), got, ref_load(f3, a, kind == K_IF));
            end
        end
        rdy_in = 1'b1;
        io_buffer_full = 1'b0;

        // Reset in cycle 2 of an SW
        wr0 = wr_count;
        next_cycle();
        set_req(K_ST, F3_SW, 32'h6000, 32'h0102_0304);
        p_st = 0;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            if (c == 2) begin rst_in = 1'b0; clear_req(); end
            if (c == 3) rst_in = 1'b1;
            @(negedge clk_in);
            if (c == 3) begin
                check("rst_mid_bus", {bus.mem_wr, bus.mem_dout, 23'd0}, 32'd0);
                check("rst_mid_mem_a", bus.mem_a, 32'd0);
                check("rst_mid_data_load", bus.data_load, 32'd0);
                check("rst_mid_ifetch_data", bus.ifetch_data, 32'd0);
            end
            if (c >= 3 && dones() != 3'b000) p_st++;
        end
        check("rst_mid_writes", 32'(wr_count - wr0), 32'd2);
        check("rst_mid_no_done", 32'(p_st), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
